// File: rtl/brute_force_pkg.sv
// Shared types and defaults for the brute-force candidate generator.
package brute_force_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] DEF_CHAR_MIN = 8'h20;
  localparam logic [7:0] DEF_CHAR_MAX = 8'h7E;

  // Width needed to hold a length of 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/brute_force_gen_if.sv
// Candidate stream between the generator (master) and its consumer (slave).
interface brute_force_gen_if #(
  parameter int MAX_LEN = 16
) ();
  localparam int LEN_W = brute_force_pkg::len_width(MAX_LEN);

  logic                 cand_valid;
  logic                 cand_ready;
  logic [8*MAX_LEN-1:0] candidate;
  logic [LEN_W-1:0]     num_chars;

  modport master (output cand_valid, candidate, num_chars, input cand_ready);
  modport slave  (input cand_valid, candidate, num_chars, output cand_ready);
endinterface

// File: rtl/char_digit.sv
// One candidate character: loads a value, steps by `step` on inc_in and wraps
// to wrap_start with a carry once the next value would pass LIMIT.
module char_digit #(
  parameter logic [7:0] LIMIT = 8'h7E
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       inc_in,
  input  logic [7:0] wrap_start,
  input  logic [7:0] step,
  output logic       carry_out,
  output logic [7:0] value
);

  logic [8:0] sum;

  assign sum       = {1'b0, value} + {1'b0, step};
  assign carry_out = inc_in && (sum > {1'b0, LIMIT});

  // NOTE: registers use non-blocking assignments so every digit samples the
  // same pre-edge carry chain; blocking here would create ordering races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_value;
    end else if (inc_in) begin
      value <= carry_out ? wrap_start : sum[7:0];
    end
  end

endmodule

// File: rtl/brute_force_gen.sv
// Exhaustive candidate generator: odometer of char_digit cells, character 0
// fastest, growing the length on overflow until MAX_LEN wraps.
module brute_force_gen
  import brute_force_pkg::*;
#(
  parameter int         MIN_LEN  = 1,
  parameter int         MAX_LEN  = 16,
  parameter logic [7:0] CHAR_MIN = DEF_CHAR_MIN,
  parameter logic [7:0] CHAR_MAX = DEF_CHAR_MAX
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic [7:0]        start_pos,
  input  logic [2:0]        stride,
  brute_force_gen_if.master cand,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cand_count
);

  localparam int LEN_W = len_width(MAX_LEN);

  state_t               state_q;
  logic [LEN_W-1:0]     num_chars_q;
  logic [31:0]          count_q;
  logic [7:0]           start_q;
  logic [2:0]           stride_q;

  logic                 start_ok;
  logic                 start_oob;
  logic [7:0]           start_clamped;
  logic [2:0]           stride_eff;
  logic                 advance;
  logic                 top_carry;
  logic                 grow;
  logic                 finish;
  logic [MAX_LEN-1:0]   carry_vec;
  logic [8*MAX_LEN-1:0] cand_bits;

  assign start_ok      = enable && start && (state_q != ST_RUN);
  assign start_oob     = start_pos > CHAR_MAX;
  assign start_clamped = (start_pos < CHAR_MIN) ? CHAR_MIN : start_pos;
  assign stride_eff    = (stride == 3'd0) ? 3'd1 : stride;

  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign cand.cand_valid = busy && enable;
  assign cand.candidate  = cand_bits;
  assign cand.num_chars  = num_chars_q;
  assign cand_count      = count_q;
  assign advance         = cand.cand_valid && cand.cand_ready;

  // Carry out of the current top character decides growth or exhaustion.
  // NOTE: top_carry gets a default before the loop so no latch is inferred.
  always_comb begin
    top_carry = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i + 1) == num_chars_q) top_carry = carry_vec[i];
    end
  end

  assign grow   = top_carry && (num_chars_q < LEN_W'(MAX_LEN));
  assign finish = top_carry && (num_chars_q == LEN_W'(MAX_LEN));

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_digit
    localparam logic [7:0] INIT_VAL = (i < MIN_LEN) ? CHAR_MIN : 8'h00;

    logic       inc;
    logic       carry;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] wrap_start;
    logic [7:0] step;
    logic [7:0] value;

    if (i == 0) begin : g_first
      assign inc        = advance;
      assign wrap_start = start_q;
      assign step       = {5'b0, stride_q};
      assign load_value = start_ok ? start_clamped : CHAR_MIN;
    end else begin : g_rest
      // Only characters inside the current length receive the carry.
      assign inc        = g_digit[i-1].carry && (LEN_W'(i) < num_chars_q);
      assign wrap_start = CHAR_MIN;
      assign step       = 8'd1;
      assign load_value = start_ok ? INIT_VAL : CHAR_MIN;
    end

    assign load = start_ok || (grow && (LEN_W'(i) == num_chars_q));

    char_digit #(
      .LIMIT (CHAR_MAX)
    ) u_digit (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_value (load_value),
      .inc_in     (inc),
      .wrap_start (wrap_start),
      .step       (step),
      .carry_out  (carry),
      .value      (value)
    );

    assign carry_vec[i]        = carry;
    assign cand_bits[8*i +: 8] = value;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      num_chars_q <= '0;
      count_q     <= '0;
      start_q     <= 8'h00;
      stride_q    <= 3'd1;
    end else if (start_ok) begin
      num_chars_q <= LEN_W'(MIN_LEN);
      count_q     <= '0;
      start_q     <= start_clamped;
      stride_q    <= stride_eff;
      state_q     <= start_oob ? ST_DONE : ST_RUN;
    end else if (advance) begin
      if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
      if (grow)   num_chars_q <= num_chars_q + 1'b1;
      if (finish) state_q     <= ST_DONE;
    end
  end

endmodule

// File: tb/tb_brute_force_gen.sv
// Bench for brute_force_gen: candidate sequences compared against an
// enumeration model built from the key-space rules.
module tb_brute_force_gen;
  import brute_force_pkg::*;

  localparam int MIN_L = 1;
  localparam int MAX_L = 2;
  localparam int C_MIN = 'h61;
  localparam int C_MAX = 'h63;
  localparam int LEN_W = len_width(MAX_L);

  typedef struct {
    logic [8*MAX_L-1:0] cand;
    int                 len;
  } cand_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         start_pos = 8'h00;
  logic [2:0]         stride = 3'd0;
  logic               busy;
  logic               done;
  logic [31:0]        cand_count;

  int    n_cmp = 0;
  int    n_fail = 0;
  cand_t exp_q[$];

  brute_force_gen_if #(.MAX_LEN(MAX_L)) cand_if ();

  brute_force_gen #(
    .MIN_LEN  (MIN_L),
    .MAX_LEN  (MAX_L),
    .CHAR_MIN (8'h61),
    .CHAR_MAX (8'h63)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .start_pos  (start_pos),
    .stride     (stride),
    .cand       (cand_if),
    .busy       (busy),
    .done       (done),
    .cand_count (cand_count)
  );

  always #5 clock = ~clock;

  // Every candidate of the key space in issue order: per length, index idx
  // maps to char0 = set0[idx mod |set0|], higher characters in base R.
  task automatic build_expected(input logic [7:0] sp, input logic [2:0] st);
    int step;
    int s;
    int r;
    int total;
    int c0[$];
    exp_q.delete();
    if (int'(sp) > C_MAX) return;
    step = (st == 3'd0) ? 1 : int'(st);
    s    = (int'(sp) < C_MIN) ? C_MIN : int'(sp);
    for (int v = s; v <= C_MAX; v += step) c0.push_back(v);
    r = C_MAX - C_MIN + 1;
    for (int len = MIN_L; len <= MAX_L; len++) begin
      total = c0.size();
      for (int d = 1; d < len; d++) total = total * r;
      for (int idx = 0; idx < total; idx++) begin
        cand_t e;
        int    rest;
        e.cand = '0;
        e.len  = len;
        e.cand[7:0] = 8'(c0[idx % c0.size()]);
        rest = idx / c0.size();
        for (int d = 1; d < len; d++) begin
          e.cand[8*d +: 8] = 8'(C_MIN + rest % r);
          rest = rest / r;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall plus a stray start.
  task automatic run_search(input logic [7:0] sp, input logic [2:0] st,
                            input int mode, input string tag);
    int                 idx;
    bit                 fin;
    logic               rdy;
    logic               prev_stall;
    logic [8*MAX_L-1:0] prev_cand;
    build_expected(sp, st);
    @(negedge clock);
    start = 1'b1; start_pos = sp; stride = st;
    @(negedge clock);
    start = 1'b0; start_pos = 8'($urandom); stride = 3'($urandom);
    n_cmp++;
    if (exp_q.size() == 0) begin
      if (cand_if.cand_valid !== 1'b0 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL %s first_cycle: valid=%b done=%b, required valid=0 done=1",
                 tag, cand_if.cand_valid, done);
      end
    end else if (cand_if.cand_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s first_cycle: valid=%b busy=%b, required 1 1",
               tag, cand_if.cand_valid, busy);
    end
    idx = 0; fin = 0; prev_stall = 1'b0; prev_cand = '0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (done === 1'b1) begin
        fin = 1;
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = !(cyc >= 3 && cyc <= 5);
        endcase
        if (mode == 2 && cyc == 4) begin
          start = 1'b1; start_pos = 8'h63; stride = 3'd3;
        end
        if (prev_stall) begin
          n_cmp++;
          if (cand_if.candidate !== prev_cand) begin
            n_fail++;
            $display("FAIL %s stall_hold: candidate=%h, required %h", tag, cand_if.candidate, prev_cand);
          end
        end
        if (mode == 0) begin
          n_cmp++;
          if (cand_if.cand_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s per_cycle_valid: valid=%b, required 1", tag, cand_if.cand_valid);
          end
        end
        if (cand_if.cand_valid === 1'b1 && rdy) begin
          n_cmp++;
          if (idx >= exp_q.size()) begin
            n_fail++;
            $display("FAIL %s overrun: candidate=%h beyond %0d expected", tag, cand_if.candidate, exp_q.size());
          end else if (cand_if.candidate !== exp_q[idx].cand ||
                       cand_if.num_chars !== LEN_W'(exp_q[idx].len) ||
                       cand_count !== 32'(idx)) begin
            n_fail++;
            $display("FAIL %s cand[%0d]: got %h/len %0d/count %0d, required %h/len %0d/count %0d",
                     tag, idx, cand_if.candidate, cand_if.num_chars, cand_count,
                     exp_q[idx].cand, exp_q[idx].len, idx);
          end
          idx++;
        end
        prev_stall = (cand_if.cand_valid === 1'b1) && !rdy;
        prev_cand  = cand_if.candidate;
        cand_if.cand_ready = rdy;
        @(negedge clock);
        start = 1'b0;
      end
    end
    n_cmp++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: done=%b after 400 cycles, required 1", tag, done);
    end
    n_cmp++;
    if (idx != exp_q.size() || cand_count !== 32'(exp_q.size()) || cand_if.cand_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: accepted=%0d count=%0d valid=%b, required %0d %0d 0",
               tag, idx, cand_count, cand_if.cand_valid, exp_q.size(), exp_q.size());
    end
    cand_if.cand_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; cand_if.cand_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (cand_if.cand_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b, required 0 0 0", cand_if.cand_valid, busy, done);
    end
    n_cmp++;
    if (cand_if.candidate !== '0 || cand_if.num_chars !== '0 || cand_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: cand=%h len=%0d count=%0d, required 0 0 0",
               cand_if.candidate, cand_if.num_chars, cand_count);
    end
    reset_n = 1'b1;
    enable = 1'b0; start = 1'b1; start_pos = 8'h61; stride = 3'd1;
    @(negedge clock);
    start = 1'b0; enable = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || cand_if.cand_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_disabled: busy=%b valid=%b, required 0 0", busy, cand_if.cand_valid);
    end
  endtask

  task automatic test_basic();
    run_search(8'h61, 3'd1, 0, "basic");
  endtask

  task automatic test_partition();
    run_search(8'h62, 3'd2, 0, "partition");
  endtask

  task automatic test_backpressure();
    run_search(8'h61, 3'd1, 2, "backpressure");
  endtask

  task automatic test_out_of_range();
    run_search(8'h70, 3'd1, 0, "out_of_range");
    repeat (3) begin
      @(negedge clock);
      n_cmp++;
      if (cand_if.cand_valid !== 1'b0 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL oob_hold: valid=%b done=%b, required 0 1", cand_if.cand_valid, done);
      end
    end
  endtask

  task automatic test_clamp();
    run_search(8'h10, 3'd0, 1, "clamp");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_search(8'($urandom_range('h5E, 'h66)), 3'($urandom_range(0, 7)), 1, "random");
    end
  endtask

  task automatic test_enable_reset();
    logic [8*MAX_L-1:0] held;
    logic [31:0]        held_cnt;
    int                 idx;
    build_expected(8'h61, 3'd1);
    @(negedge clock);
    start = 1'b1; start_pos = 8'h61; stride = 3'd1; cand_if.cand_ready = 1'b1;
    @(negedge clock);
    start = 1'b0; idx = 0;
    repeat (3) begin
      n_cmp++;
      if (cand_if.cand_valid !== 1'b1 || cand_if.candidate !== exp_q[idx].cand) begin
        n_fail++;
        $display("FAIL en_pre[%0d]: valid=%b cand=%h, required 1 %h",
                 idx, cand_if.cand_valid, cand_if.candidate, exp_q[idx].cand);
      end
      idx++;
      @(negedge clock);
    end
    enable = 1'b0; #1;
    held = cand_if.candidate; held_cnt = cand_count;
    n_cmp++;
    if (cand_if.cand_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop: valid=%b, required 0", cand_if.cand_valid);
    end
    repeat (5) begin
      @(negedge clock);
      n_cmp++;
      if (cand_if.cand_valid !== 1'b0 || cand_if.candidate !== held || cand_count !== held_cnt) begin
        n_fail++;
        $display("FAIL en_freeze: valid=%b cand=%h count=%0d, required 0 %h %0d",
                 cand_if.cand_valid, cand_if.candidate, cand_count, held, held_cnt);
      end
    end
    enable = 1'b1; #1;
    n_cmp++;
    if (cand_if.cand_valid !== 1'b1 || cand_if.candidate !== exp_q[idx].cand || cand_count !== 32'(idx)) begin
      n_fail++;
      $display("FAIL en_resume: valid=%b cand=%h count=%0d, required 1 %h %0d",
               cand_if.cand_valid, cand_if.candidate, cand_count, exp_q[idx].cand, idx);
    end
    @(negedge clock);
    idx++;
    n_cmp++;
    if (cand_if.candidate !== exp_q[idx].cand || cand_count !== 32'(idx)) begin
      n_fail++;
      $display("FAIL en_next: cand=%h count=%0d, required %h %0d",
               cand_if.candidate, cand_count, exp_q[idx].cand, idx);
    end
    reset_n = 1'b0; #1;
    n_cmp++;
    if (cand_if.cand_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cand_if.candidate !== '0 ||
        cand_if.num_chars !== '0 || cand_count !== 32'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: valid=%b busy=%b done=%b cand=%h len=%0d count=%0d, required all 0",
               cand_if.cand_valid, busy, done, cand_if.candidate, cand_if.num_chars, cand_count);
    end
    @(negedge clock);
    reset_n = 1'b1; cand_if.cand_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || cand_if.cand_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b valid=%b, required 0 0 0",
               busy, done, cand_if.cand_valid);
    end
  endtask

  task automatic test_restart();
    run_search(8'h61, 3'd1, 1, "restart");
  endtask

  initial begin
    cand_if.cand_ready = 1'b0;
    test_reset();
    test_basic();
    test_partition();
    test_backpressure();
    test_out_of_range();
    test_clamp();
    test_random();
    test_enable_reset();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/brute_force_gen.md
BRUTE_FORCE_GEN -- requirements
Module: brute_force_gen

Interface
REQ-001 The block SHALL have parameter MIN_LEN, default 1: initial candidate length in characters (1..MAX_LEN).
REQ-002 The block SHALL have parameter MAX_LEN, default 16: maximum candidate length in characters (1..16).
REQ-003 The block SHALL have parameter CHAR_MIN, default 8'h20: lowest character code.
REQ-004 The block SHALL have parameter CHAR_MAX, default 8'h7E: highest character code; CHAR_MAX >= CHAR_MIN.
REQ-005 The block SHALL have derived constant LEN_W = $clog2(MAX_LEN+1).
REQ-006 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port enable, input, 1 bit: 0 freezes all state and forces cand_valid low.
REQ-009 The block SHALL have port start, input, 1 bit: single-cycle pulse; begins a search from IDLE or DONE.
REQ-010 The block SHALL have port start_pos, input, 8 bits: first code for character 0; sampled on start.
REQ-011 The block SHALL have port stride, input, 3 bits: character-0 step; sampled on start; 0 is treated as 1.
REQ-012 The block SHALL have port cand_ready, input, 1 bit: the consumer accepts the candidate.
REQ-013 The block SHALL have port cand_valid, output, 1 bit: candidate and num_chars are valid.
REQ-014 The block SHALL have port candidate, output, 8*MAX_LEN bits: character i occupies bits [8i+7:8i]; character 0 varies fastest.
REQ-015 The block SHALL have port num_chars, output, LEN_W bits: current candidate length.
REQ-016 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-017 The block SHALL have port done, output, 1 bit: high in DONE; the key space is exhausted.
REQ-018 The block SHALL have port cand_count, output, 32 bits: accepted-candidate count, saturating at 32'hFFFFFFFF.

Function
REQ-019 States SHALL be IDLE, RUN and DONE; the transitions SHALL be:
  - IDLE or DONE -> RUN on start with enable high.
  - RUN -> DONE on acceptance of the final candidate.
  - start in RUN SHALL be ignored.
REQ-020 On start:
  - num_chars SHALL be set to MIN_LEN.
  - Character 0 SHALL be set to start_pos.
  - Characters 1..MIN_LEN-1 SHALL be set to CHAR_MIN.
  - Unused characters SHALL be set to 8'h00.
  - cand_count SHALL be cleared.
  - cand_valid SHALL rise the next cycle, giving a latency of 1 cycle.
REQ-021 If start_pos < CHAR_MIN, it SHALL be clamped to CHAR_MIN; if start_pos > CHAR_MAX, the block SHALL go directly to DONE with no candidate issued.
REQ-022 Character 0 values SHALL be the set {start_pos + k*stride <= CHAR_MAX}; it SHALL wrap to the latched start_pos and generate a carry.
REQ-023 Characters 1..num_chars-1 SHALL step by 1 from CHAR_MIN to CHAR_MAX; wrapping to CHAR_MIN SHALL generate a carry into the next character.
REQ-024 All carry propagation SHALL be synchronous within one cycle; no derived or ripple clocks are permitted.
REQ-025 On a carry out of character num_chars-1 with num_chars < MAX_LEN:
  - num_chars SHALL increment.
  - The new top character SHALL be set to CHAR_MIN.
  - Lower characters SHALL wrap per REQ-022 and REQ-023.
REQ-026 On a carry out of character num_chars-1 with num_chars == MAX_LEN, the block SHALL enter DONE, and cand_valid SHALL fall the next cycle.
REQ-027 The block SHALL advance only on cand_valid && cand_ready; while cand_ready is low, candidate and num_chars SHALL be held stable.
REQ-028 With cand_ready held high, the block SHALL issue one new candidate per cycle.
REQ-029 Bytes at index >= num_chars SHALL always be 8'h00.
REQ-030 When enable falls during RUN, cand_valid SHALL drop and no state shall change; when enable returns, the same candidate SHALL be re-presented.
REQ-031 cand_count SHALL increment by 1 on each acceptance.

Reset
REQ-032 While reset_n is low, the block SHALL be in IDLE with the following values:
  - cand_valid = 0, busy = 0, done = 0.
  - candidate = 0, num_chars = 0, cand_count = 0.
  - Latched start_pos = 0 and latched stride = 1.
REQ-033 A reset mid-RUN SHALL abort the search immediately; on release the block SHALL wait in IDLE for start.

Structure
REQ-034 The state encoding, CHAR_MIN/CHAR_MAX defaults and LEN_W function SHALL be placed in a shared package, brute_force_pkg.
REQ-035 One sub-module, char_digit, SHALL be used and instantiated MAX_LEN times:
  - It SHALL hold one 8-bit character with parameters for wrap start, step and limit.
  - Its ports SHALL be load, inc_in, carry_out and value.

Verification
REQ-036 Basic sequence:
  - Setup: MIN_LEN=1, MAX_LEN=2, CHAR 61..63, start_pos 61, stride 1, cand_ready=1.
  - Required candidates: 61, 62, 63, 6161, 6162, 6163, 6261, ... 6363.
  - Then done=1 and cand_count=12.
REQ-037 Partitioned start:
  - Setup: same parameters, start_pos 62, stride 2.
  - Required candidates: 62, 6162, 6262, 6362; then done=1 and cand_count=4.
REQ-038 Backpressure: with cand_ready low for 3 cycles mid-run, candidate SHALL stay constant; resuming SHALL show no skipped or duplicated value.
REQ-039 Out-of-range start: start_pos=8'h70 with CHAR_MAX 63 SHALL assert done the cycle after start, with no cand_valid pulse.
REQ-040 Enable and reset:
  - enable=0 for 5 cycles SHALL freeze cand_count and candidate.
  - reset_n low mid-run SHALL immediately clear all outputs to their reset values.
  - A new start SHALL restart from start_pos.
